// File: rtl/dl_cycle_reporter.sv
// Deadlock cycle reporter: debounces per-process deadlock flags, then traces a token
// from the lowest blocked process and reports the dependency loop it observed.
module dl_cycle_reporter #(
  parameter int PROC_NUM      = 3,
  parameter int DEBOUNCE      = 4,
  parameter int TRACE_TIMEOUT = 64,
  localparam int IDX_W        = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
  input  logic                dl_clock,
  input  logic                dl_reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  input  logic                all_finish,
  input  logic                report_ready,
  output logic                dl_detect_out,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                report_valid,
  output logic [IDX_W-1:0]    report_origin_idx,
  output logic [PROC_NUM-1:0] report_loop_mask,
  output logic                report_timeout,
  output logic [31:0]         report_cycle
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_TRACE  = 3'd1;
  localparam logic [2:0] S_REPORT = 3'd2;
  localparam logic [2:0] S_CLEAR  = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam logic [7:0]  DEB_LIM   = 8'(DEBOUNCE);
  localparam logic [15:0] TRACE_LIM = 16'(TRACE_TIMEOUT - 1);

  logic [2:0]          state_reg, state_next;
  logic [7:0]          deb_reg, deb_next;
  logic [15:0]         trace_reg, trace_next;
  logic [31:0]         cycle_reg, cycle_next;
  logic [PROC_NUM-1:0] origin_reg, origin_next;
  logic [PROC_NUM-1:0] loop_mask_reg, loop_mask_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic                timeout_reg, timeout_next;
  logic [31:0]         rcycle_reg, rcycle_next;
  logic                token_clear_reg, token_clear_next;

  logic                      active;
  logic [7:0]                deb_inc;
  logic [PROC_NUM-1:0]       lowest_bit;
  logic [IDX_W-1:0]          lowest_idx;
  logic [IDX_W-1:0][PROC_NUM-1:0] idx_sel;

  assign active     = (|dl_in_vec) & ~all_finish;
  assign deb_inc    = deb_reg + 8'd1;
  assign lowest_bit = dl_in_vec & (~dl_in_vec + PROC_NUM'(1));

  // One-hot to binary: index bit gi is the OR of all processes whose number has bit gi set.
  for (genvar gi = 0; gi < IDX_W; gi++) begin : g_enc
    for (genvar gj = 0; gj < PROC_NUM; gj++) begin : g_bit
      if (((gj >> gi) & 1) != 0) begin : g_on
        assign idx_sel[gi][gj] = lowest_bit[gj];
      end else begin : g_off
        assign idx_sel[gi][gj] = 1'b0;
      end
    end
    assign lowest_idx[gi] = |idx_sel[gi];
  end

  always_comb begin
    state_next       = state_reg;
    deb_next         = deb_reg;
    trace_next       = trace_reg;
    cycle_next       = (cycle_reg == 32'hFFFF_FFFF) ? cycle_reg : cycle_reg + 32'd1;
    origin_next      = origin_reg;
    loop_mask_next   = loop_mask_reg;
    idx_next         = idx_reg;
    timeout_next     = timeout_reg;
    rcycle_next      = rcycle_reg;
    token_clear_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!active) begin
          deb_next = 8'd0;
        end else if (deb_inc == DEB_LIM) begin
          state_next     = S_TRACE;
          deb_next       = 8'd0;
          origin_next    = lowest_bit;
          idx_next       = lowest_idx;
          rcycle_next    = cycle_reg;
          loop_mask_next = '0;
          trace_next     = 16'd0;
          timeout_next   = 1'b0;
        end else begin
          deb_next = deb_inc;
        end
      end
      S_TRACE: begin
        if (all_finish) begin
          state_next       = S_IDLE;
          origin_next      = '0;
          token_clear_next = 1'b1;
        end else begin
          loop_mask_next = loop_mask_reg | dl_in_vec;
          trace_next     = trace_reg + 16'd1;
          // Closure wins a tie with the timeout.
          if (((dl_in_vec & origin_reg) != '0) && (trace_reg != 16'd0)) begin
            state_next   = S_REPORT;
            timeout_next = 1'b0;
          end else if (trace_reg == TRACE_LIM) begin
            state_next   = S_REPORT;
            timeout_next = 1'b1;
          end
        end
      end
      S_REPORT: begin
        if (report_ready) begin
          state_next       = S_CLEAR;
          origin_next      = '0;
          token_clear_next = 1'b1;
        end
      end
      S_CLEAR: state_next = S_HOLD;
      S_HOLD:  state_next = S_HOLD;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge dl_clock or posedge dl_reset) begin
    if (dl_reset) begin
      state_reg       <= S_IDLE;
      deb_reg         <= 8'd0;
      trace_reg       <= 16'd0;
      cycle_reg       <= 32'd0;
      origin_reg      <= '0;
      loop_mask_reg   <= '0;
      idx_reg         <= '0;
      timeout_reg     <= 1'b0;
      rcycle_reg      <= 32'd0;
      token_clear_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      deb_reg         <= deb_next;
      trace_reg       <= trace_next;
      cycle_reg       <= cycle_next;
      origin_reg      <= origin_next;
      loop_mask_reg   <= loop_mask_next;
      idx_reg         <= idx_next;
      timeout_reg     <= timeout_next;
      rcycle_reg      <= rcycle_next;
      token_clear_reg <= token_clear_next;
    end
  end

  assign dl_detect_out     = (state_reg != S_IDLE);
  assign report_valid      = (state_reg == S_REPORT);
  assign origin            = origin_reg;
  assign token_clear       = token_clear_reg;
  assign report_origin_idx = idx_reg;
  assign report_loop_mask  = loop_mask_reg;
  assign report_timeout    = timeout_reg;
  assign report_cycle      = rcycle_reg;

endmodule

// File: tb/tb_dl_cycle_reporter.sv
// Directed bench for dl_cycle_reporter: stimulus pushes expected reports, a monitor
// pops and compares them on every report handshake.
`timescale 1ns/1ps
module tb_dl_cycle_reporter;

  logic       dl_clock = 1'b0;
  logic       dl_reset = 1'b1;
  logic [2:0] dl_in_vec = 3'b000;
  logic       all_finish = 1'b0;
  logic       report_ready = 1'b0;
  logic       dl_detect_out;
  logic [2:0] origin;
  logic       token_clear;
  logic       report_valid;
  logic [1:0] report_origin_idx;
  logic [2:0] report_loop_mask;
  logic       report_timeout;
  logic [31:0] report_cycle;

  typedef struct packed {
    logic [1:0]  idx;
    logic [2:0]  mask;
    logic        to;
    logic [31:0] cyc;
  } rpt_t;

  rpt_t exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 dl_clock = ~dl_clock;

  dl_cycle_reporter #(.PROC_NUM(3), .DEBOUNCE(4), .TRACE_TIMEOUT(16)) dut (
    .dl_clock(dl_clock),
    .dl_reset(dl_reset),
    .dl_in_vec(dl_in_vec),
    .all_finish(all_finish),
    .report_ready(report_ready),
    .dl_detect_out(dl_detect_out),
    .origin(origin),
    .token_clear(token_clear),
    .report_valid(report_valid),
    .report_origin_idx(report_origin_idx),
    .report_loop_mask(report_loop_mask),
    .report_timeout(report_timeout),
    .report_cycle(report_cycle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge dl_clock);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, 32'({dl_detect_out, origin, token_clear, report_valid}), 32'd0);
    chk({name, "_fld"}, 32'({report_origin_idx, report_loop_mask, report_timeout}), 32'd0);
    chk({name, "_cyc"}, report_cycle, 32'd0);
  endtask

  task automatic do_reset();
    dl_in_vec    = 3'b000;
    all_finish   = 1'b0;
    report_ready = 1'b0;
    dl_reset     = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    dl_reset = 1'b0;
  endtask

  // Monitor: every accepted report must match the oldest expected one.
  always @(negedge dl_clock) begin
    if (!dl_reset && report_valid && report_ready) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_report: got idx=%0d mask=%b required no report",
                 report_origin_idx, report_loop_mask);
      end else begin
        rpt_t e;
        e = exp_q.pop_front();
        $display("report idx=%0d mask=%b timeout=%0d cycle=%0d",
                 report_origin_idx, report_loop_mask, report_timeout, report_cycle);
        chk("mon_idx", 32'(report_origin_idx), 32'(e.idx));
        chk("mon_mask", 32'(report_loop_mask), 32'(e.mask));
        chk("mon_timeout", 32'(report_timeout), 32'(e.to));
        chk("mon_cycle", report_cycle, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // A: detection latency and closed loop 100 -> 001 -> 010
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    dl_in_vec = 3'b110;
    for (int i = 10; i < 13; i++) begin
      tick();
      chk("A_debounce_wait", 32'(dl_detect_out), 32'd0);
    end
    tick();
    chk("A_detect", 32'(dl_detect_out), 32'd1);
    chk("A_origin", 32'(origin), 32'b010);
    exp_q.push_back(rpt_t'{2'd1, 3'b111, 1'b0, 32'd13});
    dl_in_vec = 3'b100; tick();
    dl_in_vec = 3'b001; tick();
    chk("A_no_report_yet", 32'(report_valid), 32'd0);
    dl_in_vec = 3'b010; tick();
    chk("A_report_valid", 32'(report_valid), 32'd1);
    report_ready = 1'b1;
    tick();
    chk("A_clear_pulse", 32'(token_clear), 32'd1);
    chk("A_clear_origin", 32'(origin), 32'd0);
    chk("A_clear_valid", 32'(report_valid), 32'd0);
    tick();
    chk("A_pulse_end", 32'(token_clear), 32'd0);
    chk("A_hold_detect", 32'(dl_detect_out), 32'd1);
    chk("A_hold_cycle", report_cycle, 32'd13);

    // B: glitches do not detect, then a timed-out trace with slow consumer
    do_reset();
    dl_in_vec = 3'b001;
    for (int i = 0; i < 3; i++) begin tick(); chk("B_glitch1", 32'(dl_detect_out), 32'd0); end
    dl_in_vec = 3'b000; tick(); tick();
    dl_in_vec = 3'b001;
    for (int i = 0; i < 3; i++) begin tick(); chk("B_glitch2", 32'(dl_detect_out), 32'd0); end
    dl_in_vec = 3'b000; tick();
    dl_in_vec = 3'b001;
    for (int i = 0; i < 3; i++) begin tick(); chk("B_debounce", 32'(dl_detect_out), 32'd0); end
    tick();
    chk("B_detect", 32'(dl_detect_out), 32'd1);
    chk("B_origin", 32'(origin), 32'b001);
    exp_q.push_back(rpt_t'{2'd0, 3'b110, 1'b1, 32'd12});
    dl_in_vec = 3'b110;
    for (int i = 0; i < 15; i++) begin tick(); chk("B_tracing", 32'(report_valid), 32'd0); end
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("B_stall_valid", 32'(report_valid), 32'd1);
      chk("B_stall_fields", 32'({report_origin_idx, report_loop_mask, report_timeout}), 32'b00_110_1);
      chk("B_stall_cycle", report_cycle, 32'd12);
      tick();
    end
    chk("B_still_valid", 32'(report_valid), 32'd1);
    report_ready = 1'b1;
    tick();
    chk("B_clear_pulse", 32'(token_clear), 32'd1);
    dl_in_vec = 3'b111;
    all_finish = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("B_hold_ctl", 32'({dl_detect_out, token_clear, report_valid, origin}), 32'b1_0_0_000);
      chk("B_hold_timeout", 32'(report_timeout), 32'd1);
      tick();
    end

    // C: origin seen on first trace cycle ignored; closure ties with timeout
    do_reset();
    report_ready = 1'b1;
    dl_in_vec = 3'b001;
    for (int i = 0; i < 4; i++) tick();
    chk("C_origin", 32'(origin), 32'b001);
    exp_q.push_back(rpt_t'{2'd0, 3'b101, 1'b0, 32'd3});
    tick();
    chk("C_no_early_close", 32'(report_valid), 32'd0);
    dl_in_vec = 3'b100;
    for (int i = 0; i < 14; i++) begin tick(); chk("C_tracing", 32'(report_valid), 32'd0); end
    dl_in_vec = 3'b001;
    tick();
    chk("C_report_valid", 32'(report_valid), 32'd1);
    chk("C_tie_timeout", 32'(report_timeout), 32'd0);
    tick();
    chk("C_one_cycle_valid", 32'(report_valid), 32'd0);
    chk("C_clear_pulse", 32'(token_clear), 32'd1);

    // D: all_finish aborts the trace
    do_reset();
    report_ready = 1'b1;
    dl_in_vec = 3'b010;
    for (int i = 0; i < 4; i++) tick();
    chk("D_detect", 32'(dl_detect_out), 32'd1);
    dl_in_vec = 3'b100;
    tick(); tick();
    all_finish = 1'b1;
    tick();
    chk("D_abort", 32'({dl_detect_out, token_clear, report_valid, origin}), 32'b0_1_0_000);
    tick();
    chk("D_pulse_end", 32'(token_clear), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("D_idle", 32'({dl_detect_out, report_valid}), 32'd0);
    end
    all_finish = 1'b0;

    // E: asynchronous reset in REPORT, then a fresh detection
    do_reset();
    dl_in_vec = 3'b010;
    for (int i = 0; i < 4; i++) tick();
    tick(); tick();
    chk("E_report_valid", 32'(report_valid), 32'd1);
    #3;
    dl_reset = 1'b1;
    #1;
    chk_all_zero("E_async");
    do_reset();
    tick(); tick();
    dl_in_vec = 3'b100;
    for (int i = 0; i < 4; i++) tick();
    chk("E_origin", 32'(origin), 32'b100);
    exp_q.push_back(rpt_t'{2'd2, 3'b100, 1'b0, 32'd5});
    tick(); tick();
    chk("E_report_valid2", 32'(report_valid), 32'd1);
    report_ready = 1'b1;
    tick();
    tick();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dl_cycle_reporter.md
DL_CYCLE_REPORTER -- requirements
Module: dl_cycle_reporter

Interface
REQ-001 SHALL have parameter PROC_NUM, default 3: number of monitored dataflow processes (1..32).
REQ-002 SHALL have parameter DEBOUNCE, default 4: consecutive cycles dl_in_vec must be nonzero before detection (1..255).
REQ-003 SHALL have parameter TRACE_TIMEOUT, default 64: maximum trace cycles before a forced report (2..65535).
REQ-004 SHALL use IDX_W = max(1, ceil(log2(PROC_NUM))) for index widths.
REQ-005 dl_clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 dl_reset  in  1  reset, asynchronous and active-high.
REQ-007 dl_in_vec  in  PROC_NUM  per-process deadlock flags from the detect units; bit i = process i blocked or holding the token.
REQ-008 all_finish  in  1  design completed; suppresses detection.
REQ-009 report_ready  in  1  consumer accepts the report.
REQ-010 dl_detect_out  out  1  deadlock declared; broadcast to all detect units.
REQ-011 origin  out  PROC_NUM  one-hot origin process that launches the token.
REQ-012 token_clear  out  1  single-cycle pulse that clears all circulating tokens.
REQ-013 report_valid  out  1  report fields valid.
REQ-014 report_origin_idx  out  IDX_W  binary index of the origin process.
REQ-015 report_loop_mask  out  PROC_NUM  processes seen in the dependency loop.
REQ-016 report_timeout  out  1  trace ended by timeout, not by loop closure.
REQ-017 report_cycle  out  32  cycle count at detection.

Function
REQ-018 SHALL implement the FSM states IDLE, TRACE, REPORT, CLEAR, HOLD.
REQ-019 SHALL run a 32-bit cycle counter from reset that saturates at 0xFFFFFFFF.
REQ-020 IDLE, debounce: the debounce counter SHALL increment while (|dl_in_vec) & ~all_finish, and clear otherwise.
REQ-021 IDLE exit: when the debounce counter reaches DEBOUNCE, the next state SHALL be TRACE; on that edge the block SHALL set dl_detect_out=1, load origin with the lowest set bit of dl_in_vec, capture report_cycle, and clear loop_mask and the trace counter.
REQ-022 TRACE accumulate: each cycle, loop_mask SHALL be ORed with dl_in_vec, and the trace counter SHALL increment.
REQ-023 TRACE closure: if (dl_in_vec & origin) != 0 and trace counter >= 1, the next state SHALL be REPORT with report_timeout=0.
REQ-024 TRACE timeout: if the trace counter reaches TRACE_TIMEOUT-1 without closure, the next state SHALL be REPORT with report_timeout=1.
REQ-025 TRACE tie: closure and timeout in the same cycle SHALL resolve as closure.
REQ-026 TRACE abort: all_finish=1 SHALL override closure and timeout; token_clear SHALL pulse for 1 cycle, dl_detect_out and origin SHALL clear, no report is produced, and the next state SHALL be IDLE.
REQ-027 REPORT: report_valid SHALL be 1 with all report fields stable; the transfer occurs when report_valid & report_ready, and the next state SHALL be CLEAR.
REQ-028 REPORT: report_ready asserted on the cycle of entry SHALL complete the transfer in that cycle (1-cycle minimum valid).
REQ-029 CLEAR: token_clear=1 for exactly 1 cycle, origin SHALL clear to 0, report_valid SHALL be 0, and the next state SHALL be HOLD.
REQ-030 HOLD: dl_detect_out SHALL remain 1 and the report fields SHALL retain their values until reset; dl_in_vec and all_finish SHALL be ignored.
REQ-031 dl_detect_out SHALL be 1 in TRACE, REPORT, CLEAR and HOLD, and 0 in IDLE.
REQ-032 report_origin_idx SHALL equal the binary encoding of origin as captured at detection.
REQ-033 dl_in_vec bits SHALL be sampled without synchronization, because they are same-clock-domain signals.

Reset
REQ-034 While dl_reset=1, the block SHALL be in state IDLE with every output 0, and the debounce, trace and cycle counters, loop_mask and report registers at 0.
REQ-035 dl_reset asserted in any state SHALL force these values asynchronously, with no token_clear pulse.
REQ-036 After reset deassertion, the first rising edge SHALL count as cycle 0, and operation SHALL resume from IDLE.

Verification (PROC_NUM=3, DEBOUNCE=4, TRACE_TIMEOUT=16)
REQ-037 dl_in_vec=3'b000 held, then 3'b110 held from cycle 10 -> dl_detect_out=1 after edge 13, origin=3'b010, report_cycle=13.
REQ-038 Glitch: dl_in_vec=3'b001 for 3 cycles, then 0 -> no detection; debounce counter returns to 0.
REQ-039 After detection with origin=3'b010: drive 3'b100, then 3'b001, then 3'b010 -> REPORT entered, loop_mask=3'b111, report_origin_idx=1, report_timeout=0.
REQ-040 TRACE with the origin bit never asserted -> report_valid after 16 trace cycles with report_timeout=1; report_ready held low 5 cycles, then high -> fields stable throughout, token_clear 1-cycle pulse, HOLD with dl_detect_out=1.
REQ-041 all_finish=1 on the 3rd TRACE cycle -> token_clear pulse, dl_detect_out=0 next cycle, IDLE, report_valid never asserted.
REQ-042 dl_reset asserted mid-REPORT -> all outputs 0 immediately; after release, a fresh detection reports a new report_cycle.
